// File: rtl/sram_arbiter.sv
// Two-requester arbiter for a single-port SRAM; each transaction runs IDLE -> ACCESS -> DONE.
// Define SRAM_ARB_RR_EN for round-robin on contention; the default build gives requester 0 priority.
module sram_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                sel;

`ifdef SRAM_ARB_RR_EN
  logic last_q, last_d;

  // On contention the requester that did not win last time goes next.
  assign sel = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (req0 || req1)) last_d = sel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  assign sel = ~req0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACCESS;
          gnt_d   = sel;
          we_d    = sel ? we1 : we0;
          addr_d  = sel ? addr1 : addr0;
          wdata_d = sel ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!we_q) rdata_d = sram_dout;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Captured address/data only change on entry to ACCESS, so they hold their last value elsewhere.
  assign sram_addr = addr_q;
  assign sram_din  = wdata_q;
  assign sram_we   = (state_q == ACCESS) && we_q;
  assign ack0      = (state_q == DONE) && !gnt_q;
  assign ack1      = (state_q == DONE) && gnt_q;
  assign busy      = (state_q != IDLE);
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: transaction-level reference model with its own memory image,
// random requests/contention and occasional reset aborts during ACCESS.
module tb_sram_arbiter;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 1;
  localparam int NCYC   = 800;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1, busy, sram_we;
  logic [DATA_W-1:0] rdata, sram_din, sram_dout;
  logic [ADDR_W-1:0] sram_addr;

  logic [DATA_W-1:0] sram_mem [4] = '{default: '0};
  logic [DATA_W-1:0] ref_mem  [4] = '{default: '0};

  int n_vec = 0;
  int n_err = 0;
  int k = 0;
  int n_abort = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always @(posedge clk) if (sram_we) sram_mem[sram_addr] <= sram_din;
  assign sram_dout = sram_mem[sram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // Reference transaction state
  int                acc_cyc = -10, done_cyc = -10;
  logic              tr_g, tr_we, last_g;
  logic [ADDR_W-1:0] tr_addr, exp_saddr;
  logic [DATA_W-1:0] tr_wdata, tr_rd, exp_rdata, exp_sdin;
  logic              g, aborted;

  task automatic check_cycle();
    logic in_acc, in_done;
    in_acc  = (k == acc_cyc);
    in_done = (k == done_cyc);
    if (in_acc) begin
      exp_saddr = tr_addr;
      exp_sdin  = tr_wdata;
    end
    if (in_done && !tr_we) exp_rdata = tr_rd;
    check("busy",      32'(busy),      32'(in_acc || in_done));
    check("sram_we",   32'(sram_we),   32'(in_acc && tr_we));
    check("ack0",      32'(ack0),      32'(in_done && !tr_g));
    check("ack1",      32'(ack1),      32'(in_done && tr_g));
    check("rdata",     32'(rdata),     32'(exp_rdata));
    check("sram_addr", 32'(sram_addr), 32'(exp_saddr));
    check("sram_din",  32'(sram_din),  32'(exp_sdin));
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    exp_rdata = '0; exp_saddr = '0; exp_sdin = '0;
    last_g = 1'b1; tr_g = 1'b0; tr_we = 1'b0; tr_addr = '0; tr_wdata = '0; tr_rd = '0;
    repeat (2) @(negedge clk);
    check_cycle();
    rst_n = 1'b1;

    for (int c = 1; c <= NCYC; c++) begin
      @(negedge clk);
      k = c;
      check_cycle();
      aborted = 1'b0;

      if (!rst_n) begin
        rst_n = 1'b1;
      end else if (k == acc_cyc && $urandom_range(0, 5) == 0) begin
        // Reset lands on the edge that ends ACCESS: transaction dropped, state back to reset values.
        rst_n = 1'b0;
        aborted = 1'b1;
        n_abort++;
        req0 = 1'b0;
        req1 = 1'b0;
        done_cyc = k;
        exp_rdata = '0; exp_saddr = '0; exp_sdin = '0;
        last_g = 1'b1;
      end

      if (!aborted) begin
        if (k == done_cyc) begin
          if (tr_g) req1 = 1'b0;
          else      req0 = 1'b0;
        end
        if (!req0) begin
          we0 = 1'($urandom_range(0, 1));
          addr0 = ADDR_W'($urandom_range(0, 3));
          wdata0 = DATA_W'($urandom_range(0, 1));
          if (!(k == done_cyc && !tr_g) && $urandom_range(0, 9) < 6) req0 = 1'b1;
        end
        if (!req1) begin
          we1 = 1'($urandom_range(0, 1));
          addr1 = ADDR_W'($urandom_range(0, 3));
          wdata1 = DATA_W'($urandom_range(0, 1));
          if (!(k == done_cyc && tr_g) && $urandom_range(0, 9) < 6) req1 = 1'b1;
        end

        // DUT sits in IDLE this cycle and samples the requests at the next edge.
        if (k > done_cyc && (req0 || req1)) begin
          if (req0 && req1) begin
`ifdef SRAM_ARB_RR_EN
            g = (last_g == 1'b1) ? 1'b0 : 1'b1;
`else
            g = 1'b0;
`endif
          end else begin
            g = req1;
          end
          last_g   = g;
          tr_g     = g;
          tr_we    = g ? we1 : we0;
          tr_addr  = g ? addr1 : addr0;
          tr_wdata = g ? wdata1 : wdata0;
          if (tr_we) ref_mem[tr_addr] = tr_wdata;
          else       tr_rd = ref_mem[tr_addr];
          acc_cyc  = k + 1;
          done_cyc = k + 2;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, SRAM address width (4 words).
REQ-002 SHALL have parameter DATA_W, default 1, SRAM data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports req0/req1  input  1  access request per requester, held high until ack.
REQ-006 SHALL have ports we0/we1  input  1  1 = write, 0 = read; stable while req high.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_W  word address; stable while req high.
REQ-008 SHALL have ports wdata0/wdata1  input  DATA_W  write data; stable while req high.
REQ-009 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse per requester.
REQ-010 SHALL have port rdata  output  DATA_W  read data, valid in the ack cycle of a read.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port sram_addr  output  ADDR_W  SRAM address.
REQ-013 SHALL have port sram_we  output  1  SRAM write enable.
REQ-014 SHALL have port sram_din  output  DATA_W  SRAM write data.
REQ-015 SHALL have port sram_dout  input  DATA_W  SRAM combinational read data.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, DONE; every other state encoding returns to IDLE.
REQ-017 In IDLE with any req high, SHALL select one requester, register its we/addr/wdata and grant id, and go to ACCESS next cycle.
REQ-018 In IDLE with no req high, SHALL stay in IDLE; sram_we stays 0.
REQ-019 In ACCESS, SHALL drive sram_addr/sram_din from the captured values and assert sram_we for exactly this one cycle iff the captured op is a write.
REQ-020 At the end of ACCESS for a read, SHALL register sram_dout into rdata; for a write, rdata SHALL hold its previous value.
REQ-021 In DONE, SHALL assert ack of the granted requester only (other ack 0), then go to IDLE.
REQ-022 Latency SHALL be fixed: req sampled in cycle N -> ack in cycle N+2; maximum throughput one transaction per 3 cycles.
REQ-023 Requester SHALL deassert req in the cycle after ack; a req high in IDLE is always a new request.
REQ-024 Request inputs changing during ACCESS/DONE SHALL NOT affect the transaction in flight.
REQ-025 sram_addr and sram_din SHALL hold their last driven values outside ACCESS; sram_we SHALL be 0 outside ACCESS.
REQ-026 On a single request, SHALL grant that requester regardless of arbitration history.

Reset
REQ-027 With rst_n low at a rising edge, SHALL enter IDLE; ack0=ack1=0, busy=0, sram_we=0, sram_addr=0, sram_din=0, rdata=0, last-grant register=1.
REQ-028 Reset asserted during ACCESS or DONE SHALL abort the transaction: no ack issued, sram_we low from the next cycle.

Configuration
REQ-029 With macro SRAM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester not granted last wins; last-grant updates on every grant; first contended grant after reset goes to requester 0.
REQ-030 Without SRAM_ARB_RR_EN, simultaneous requests SHALL always be granted to requester 0; the last-grant register is not required.

Verification
REQ-031 Reset then req0 write addr=2'b10 wdata=1 -> sram_we=1, sram_addr=2'b10, sram_din=1 in cycle N+1 only; ack0 in N+2; ack1 stays 0.
REQ-032 After REQ-031, req1 read addr=2'b10 with model SRAM -> rdata=1 and ack1 in cycle N+2; sram_we=0 throughout.
REQ-033 Write 1 to all four addresses via req0, then write 0 to addr 2'b01, then read all four via req1 -> rdata 1,0,1,1.
REQ-034 req0 and req1 held high together for 4 transactions -> with SRAM_ARB_RR_EN grant order 0,1,0,1; without it, 0,0,0,0 while req0 stays high.
REQ-035 rst_n pulsed low during ACCESS of a write -> no ack, busy=0 and sram_we=0 next cycle, next request completes normally in 3 cycles.
